// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// State encoding and counter sizing used by serial_subtractor.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fsubr.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module fsubr (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock through a single fsubr cell.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  // Holds the WIDTH-1 result bits produced so far; the last bit comes from the cell.
  logic [WIDTH-2:0] r_sr;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_cat;

  fsubr u_fsubr (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_sr_cat = {w_d, r_sr};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_cat[WIDTH-1:1];
          r_bin <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          // Outputs only ever see a complete result.
          if (w_last) begin
            r_diff   <= w_sr_cat;
            r_borrow <= w_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a cycle-level reference model queues
// expected results, an independent monitor checks them when done pulses.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  logic c_a = 1'b0, c_b = 1'b0, c_bin = 1'b0;
  logic c_d, c_bout;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  fsubr u_cell (
    .a    (c_a),
    .b    (c_b),
    .bin  (c_bin),
    .d    (c_d),
    .bout (c_bout)
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           m_busy = 0;
  logic [W-1:0] held_diff   = '0;
  logic         held_borrow = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted request occupies the unit for W+1 cycles
  // and yields its result W edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 0;
    end else begin
      cyc++;
      if (m_busy > 0) begin
        m_busy--;
      end else if (start) begin
        exp_q.push_back('{diff: W'(a - b), borrow: (a < b), due: cyc + W});
        m_busy = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held_diff   = '0;
      held_borrow = 1'b0;
    end else begin
      chk("busy", busy, (m_busy > 0));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("diff", diff, e.diff);
          chk("borrow", borrow, e.borrow);
          held_diff   = e.diff;
          held_borrow = e.borrow;
        end
      end else begin
        chk("hold_diff", diff, held_diff);
        chk("hold_borrow", borrow, held_borrow);
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          chk("done_missing", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb);
    start = 1'b1;
    a     = xa;
    b     = xb;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && m_busy > 0; i++) tick();
    if (m_busy > 0) chk("idle_timeout", busy, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      int r;
      c_a   = i[2];
      c_b   = i[1];
      c_bin = i[0];
      #1;
      r = int'(c_a) - int'(c_b) - int'(c_bin);
      chk("fsubr_d", c_d, (r & 1) != 0);
      chk("fsubr_bout", c_bout, r < 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow, 0);
    rst_n = 1'b1;
    tick();

    op(8'h5A, 8'h3C); wait_idle();
    op(8'h00, 8'h01); wait_idle();
    op(8'h80, 8'h80); wait_idle();

    op(8'hFF, 8'h00);
    repeat (8) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
    end
    wait_idle();

    op(8'h10, 8'h01);
    tick();
    tick();
    start = 1'b1; a = 8'h02; b = 8'h05;
    tick();
    start = 1'b0;
    wait_idle();

    op(8'h33, 8'h11);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    tick();
    rst_n = 1'b1;
    tick();
    op(8'h33, 8'h11); wait_idle();

    start = 1'b1; a = 8'h07; b = 8'h09;
    repeat (40) tick();
    start = 1'b0;
    wait_idle();

    repeat (40) begin
      int gap;
      op(W'($urandom), W'($urandom));
      gap = $urandom_range(0, 14);
      for (int k = 0; k < gap; k++) begin
        start = ($urandom_range(0, 3) == 0);
        a     = W'($urandom);
        b     = W'($urandom);
        tick();
      end
      start = 1'b0;
    end
    wait_idle();
    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
